burst_split: RTL and testbench
==============================

// Module: burst_split
// PURPOSE
// - Unpacks one multi-item burst into single items. A burst is up to DEPTH lanes plus a
//   count, taken in a single valid/ready handshake.
// - Items leave one per out handshake, lane 0 first.
// - Counterpart of the gather buffer, which collects single items and releases them as a
//   group. This block sits on the return path and hands grouped data back as a single stream.
// PARAMETERS
// - DATA_W  8  width of one item
// - DEPTH   2  lanes per burst, >=1
// - CNT_W   $clog2(DEPTH+1)  width of the count field (derived; do not override)
// PORTS
// - clk          in   1             clock, rising edge
// - arst_n       in   1             reset, asynchronous, active-low
// - in_valid_i   in   1             burst present
// - in_ready_o   out  1             burst accepted when in_valid_i && in_ready_o
// - in_data_i    in   DEPTH*DATA_W  lane k = in_data_i[k*DATA_W +: DATA_W]
// - in_count_i   in   CNT_W         number of valid lanes, 0..DEPTH
// - out_valid_o  out  1             item present
// - out_ready_i  in   1             item taken when out_valid_o && out_ready_i
// - out_data_o   out  DATA_W        current item
// - out_last_o   out  1             current item is the last of its burst
// - err_o        out  1             only with BURST_SPLIT_ERR_EN; see CONFIGURATION
// - clr_err_i    in   1             only with BURST_SPLIT_ERR_EN
// BEHAVIOUR
// - Reset values: state=IDLE, out_valid_o=0, out_last_o=0, out_data_o=0, idx=0,
//   held count=0, err_o=0.
// - in_ready_o = (state==IDLE) | (state==EMIT & out_ready_i & out_last_o).
//   This is combinational from out_ready_i, which allows back-to-back bursts with no bubble.
// - Accept rules:
//   - Accept with count 0: burst is discarded; state stays or returns to IDLE; no output item.
//   - Accept with count>DEPTH: count is clamped to DEPTH.
// - Accept with count>=1:
//   - Lanes and count are registered; idx=0; state=EMIT.
//   - out_valid_o rises the cycle after accept (latency 1).
// - EMIT:
//   - out_data_o = lane[idx]; out_last_o = (idx==held_count-1).
//   - out_valid_o, out_data_o and out_last_o stay stable while out_ready_i=0.
//   - Handshake with out_last_o=0: idx increments.
//   - Handshake with out_last_o=1: go to IDLE, or reload from a simultaneous accept.
// - idx never wraps: it spans 0..DEPTH-1 and is reset to 0 on each accept.
// - DEPTH=1: every item has out_last_o=1.
// - Reset mid-burst: the remaining items are lost; outputs return to reset values
//   immediately (asynchronously).
// - out_valid_o never depends combinationally on in_valid_i.
// CONFIGURATION
// - Macro BURST_SPLIT_ERR_EN. Data path behaviour is identical with or without it.
// - Defined:
//   - err_o and clr_err_i ports exist.
//   - err_o is a sticky 1, set the cycle after accepting count==0 or count>DEPTH.
//   - clr_err_i=1 clears err_o. If a new error and clear occur in the same cycle, set wins.
// - Undefined: no err_o or clr_err_i ports and no error register; bad counts are handled
//   silently as above.
// STRUCTURE
// - burst_split_pkg holds:
//   - typedef enum logic {IDLE, EMIT} bs_state_e
//   - function clamp_cnt(cnt, depth) implementing the count clamp
// - Sub-module burst_lane_mux (DATA_W, DEPTH): combinational lane select
//   lane[idx] -> out_data_o.
// - The top level holds the FSM, lane register, idx counter, count register and error
//   flag.
// TESTING
// - DEPTH=2, DATA_W=8; burst {lane1=0xB2, lane0=0xA1}, count=2, out_ready_i=1
//   -> 0xA1 (last=0), then 0xB2 (last=1) on consecutive cycles; in_ready_o=1 on the 0xB2
//   cycle.
// - Two bursts held valid back-to-back (count 2, then count 1 = 0xC3), out_ready_i=1
//   -> A1, B2, C3 with no gap; C3 has last=1.
// - Hold out_ready_i=0 for 3 cycles on item 0xA1
//   -> out_data_o=0xA1 and out_valid_o=1 stable; in_ready_o=0.
// - count=0 burst, then count=3 burst {-,0xE5,0xD4}
//   -> no item for the first burst; second burst emits D4, E5 (clamped to 2).
//   -> With BURST_SPLIT_ERR_EN: err_o=1 after the first burst and stays 1; pulse
//      clr_err_i -> 0; second burst sets it again.
// - Drop arst_n while 0xA1 is presented
//   -> out_valid_o=0 and in_ready_o=1 at once; after release, a new burst F6 (count=1)
//      emits F6 with last=1.

Source files
------------

// File: rtl/burst_split_pkg.sv
// burst_split_pkg: shared types and helpers for the burst splitter.
//   bs_state_e : splitter FSM state (IDLE waits for a burst, EMIT hands out items)
//   clamp_cnt  : limits a requested lane count to the number of physical lanes
package burst_split_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } bs_state_e;

    function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned depth);
        return (cnt > depth) ? depth : cnt;
    endfunction

endpackage

// File: rtl/burst_lane_mux.sv
// burst_lane_mux: combinational lane select, data_o = lane[idx_i].
//   lanes_i : DEPTH*DATA_W packed lanes, lane k at [k*DATA_W +: DATA_W]
//   idx_i   : lane index, 0..DEPTH-1
//   data_o  : selected lane (zero for an out-of-range index)
module burst_lane_mux #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH*DATA_W-1:0] lanes_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [DATA_W-1:0]       data_o
);

    always_comb begin
        data_o = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (32'(idx_i) == k) begin
                data_o = lanes_i[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/burst_split.sv
// burst_split: unpacks one multi-lane burst into a stream of single items, lane 0 first.
//   clk, arst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid_i/ready_o   : burst handshake; in_data_i holds DEPTH lanes, in_count_i valid lanes
//   out_valid_o/ready_i  : item handshake; out_data_o item, out_last_o last item of its burst
//   err_o, clr_err_i     : sticky bad-count flag and its clear, present only when
//                          BURST_SPLIT_ERR_EN is defined
// Optional feature macro: BURST_SPLIT_ERR_EN
module burst_split #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DEPTH*DATA_W-1:0] in_data_i,
    input  logic [CNT_W-1:0]        in_count_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_W-1:0]       out_data_o,
    output logic                    out_last_o
`ifdef BURST_SPLIT_ERR_EN
    ,
    output logic                    err_o,
    input  logic                    clr_err_i
`endif
);

    import burst_split_pkg::*;

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bs_state_e               state_q, state_d;
    logic [DEPTH*DATA_W-1:0] lanes_q, lanes_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        count_clamped;
    logic [DATA_W-1:0]       lane_data;
    logic                    last;
    logic                    accept;
    logic                    accept_nonzero;
    logic                    item_taken;

    assign count_clamped  = CNT_W'(clamp_cnt(32'(in_count_i), DEPTH));
    // count_q is at least 1 whenever EMIT is active, so the subtraction cannot underflow there
    assign last           = (CNT_W'(idx_q) == count_q - CNT_W'(1));
    assign accept         = in_valid_i && in_ready_o;
    assign accept_nonzero = accept && (count_clamped != '0);
    assign item_taken     = (state_q == EMIT) && out_ready_i;

    burst_lane_mux #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_lane_mux (
        .lanes_i (lanes_q),
        .idx_i   (idx_q),
        .data_o  (lane_data)
    );

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            lanes_q <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lanes_q <= lanes_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; a zero-count burst is consumed without touching the held lanes
    always_comb begin
        state_d = state_q;
        lanes_d = lanes_q;
        count_d = count_q;
        idx_d   = idx_q;
        if (accept) begin
            if (accept_nonzero) begin
                state_d = EMIT;
                lanes_d = in_data_i;
                count_d = count_clamped;
                idx_d   = '0;
            end else begin
                state_d = IDLE;
            end
        end else if (item_taken) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Outputs; item fields are forced to zero outside EMIT
    always_comb begin
        out_valid_o = (state_q == EMIT);
        out_last_o  = (state_q == EMIT) && last;
        out_data_o  = (state_q == EMIT) ? lane_data : '0;
        // Accepting while the last item leaves gives back-to-back bursts without a bubble
        in_ready_o  = (state_q == IDLE) || ((state_q == EMIT) && out_ready_i && last);
    end

`ifdef BURST_SPLIT_ERR_EN
    logic err_q, err_d;
    logic bad_count;

    assign bad_count = (in_count_i == '0) || (32'(in_count_i) > DEPTH);

    always_comb begin
        err_d = err_q;
        if (clr_err_i) begin
            err_d = 1'b0;
        end
        // Setting takes priority over a simultaneous clear
        if (accept && bad_count) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_burst_split.sv
module tb_burst_split;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;

    logic                    clk;
    logic                    arst_n;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [DEPTH*DATA_W-1:0] in_data_i;
    logic [CNT_W-1:0]        in_count_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [DATA_W-1:0]       out_data_o;
    logic                    out_last_o;
`ifdef BURST_SPLIT_ERR_EN
    logic                    err_o;
    logic                    clr_err_i;
`endif

    int checks;
    int errors;

    burst_split #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_count_i  (in_count_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o)
`ifdef BURST_SPLIT_ERR_EN
        ,
        .err_o       (err_o),
        .clr_err_i   (clr_err_i)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #12;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid_o); end
        checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last_o); end
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
`ifdef BURST_SPLIT_ERR_EN
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
`endif
        arst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        in_valid_i = 1'b1; in_data_i = 16'hB2A1; in_count_i = 2'd2; out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid0 got %b want 1", out_valid_o); end
        checks++; if (out_data_o !== 8'hA1) begin errors++; $display("FAIL basic_data0 got %h want a1", out_data_o); end
        checks++; if (out_last_o !== 1'b0) begin errors++; $display("FAIL basic_last0 got %b want 0", out_last_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL basic_ready0 got %b want 0", in_ready_o); end
        step();
        checks++; if (out_data_o !== 8'hB2) begin errors++; $display("FAIL basic_data1 got %h want b2", out_data_o); end
        checks++; if (out_last_o !== 1'b1) begin errors++; $display("FAIL basic_last1 got %b want 1", out_last_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready1 got %b want 1", in_ready_o); end
        step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", out_valid_o); end
    endtask

    task automatic test_back_to_back();
        in_valid_i = 1'b1; in_data_i = 16'hB2A1; in_count_i = 2'd2; out_ready_i = 1'b1;
        step();
        in_data_i = 16'h00C3; in_count_i = 2'd1;
        checks++; if (out_data_o !== 8'hA1) begin errors++; $display("FAIL b2b_a1 got %h want a1", out_data_o); end
        step();
        checks++; if (out_data_o !== 8'hB2 || out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_b2 got %h/%b want b2/1", out_data_o, out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready_o); end
        step();
        in_valid_i = 1'b0;
        checks++; if (out_data_o !== 8'hC3 || out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_c3 got %h/%b want c3/1", out_data_o, out_valid_o); end
        checks++; if (out_last_o !== 1'b1) begin errors++; $display("FAIL b2b_c3_last got %b want 1", out_last_o); end
        step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", out_valid_o); end
    endtask

    task automatic test_stall();
        in_valid_i = 1'b1; in_data_i = 16'hB2A1; in_count_i = 2'd2; out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'hA1) begin errors++; $display("FAIL stall_hold%0d got %b/%h want 1/a1", i, out_valid_o, out_data_o); end
            checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b want 0", i, in_ready_o); end
            step();
        end
        out_ready_i = 1'b1;
        checks++; if (out_data_o !== 8'hA1) begin errors++; $display("FAIL stall_release got %h want a1", out_data_o); end
        step();
        checks++; if (out_data_o !== 8'hB2 || out_last_o !== 1'b1) begin errors++; $display("FAIL stall_b2 got %h/%b want b2/1", out_data_o, out_last_o); end
        step();
    endtask

    task automatic test_bad_count();
        in_valid_i = 1'b1; in_data_i = 16'h9988; in_count_i = 2'd0; out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL zero_no_item got %b want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", in_ready_o); end
`ifdef BURST_SPLIT_ERR_EN
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err_o); end
        step();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_o); end
        clr_err_i = 1'b1;
        step();
        clr_err_i = 1'b0;
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err_o); end
`else
        step();
`endif
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL zero_still_idle got %b want 0", out_valid_o); end
        in_valid_i = 1'b1; in_data_i = 16'hE5D4; in_count_i = 2'd3;
        step();
        in_valid_i = 1'b0;
        checks++; if (out_data_o !== 8'hD4 || out_last_o !== 1'b0) begin errors++; $display("FAIL clamp_d4 got %h/%b want d4/0", out_data_o, out_last_o); end
`ifdef BURST_SPLIT_ERR_EN
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_reset_by_clamp got %b want 1", err_o); end
`endif
        step();
        checks++; if (out_data_o !== 8'hE5 || out_last_o !== 1'b1) begin errors++; $display("FAIL clamp_e5 got %h/%b want e5/1", out_data_o, out_last_o); end
        step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL clamp_idle got %b want 0", out_valid_o); end
    endtask

    task automatic test_async_reset();
        in_valid_i = 1'b1; in_data_i = 16'hB2A1; in_count_i = 2'd2; out_ready_i = 1'b0;
        step();
        in_valid_i = 1'b0;
        checks++; if (out_data_o !== 8'hA1) begin errors++; $display("FAIL ar_pre got %h want a1", out_data_o); end
        #1;
        arst_n = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", out_valid_o); end
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ar_ready got %b want 1", in_ready_o); end
        checks++; if (out_data_o !== 8'h00) begin errors++; $display("FAIL ar_data got %h want 00", out_data_o); end
        #2;
        arst_n = 1'b1;
        step();
        out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 16'h00F6; in_count_i = 2'd1;
        step();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || out_data_o !== 8'hF6) begin errors++; $display("FAIL ar_f6 got %b/%h want 1/f6", out_valid_o, out_data_o); end
        checks++; if (out_last_o !== 1'b1) begin errors++; $display("FAIL ar_f6_last got %b want 1", out_last_o); end
        step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL ar_idle got %b want 0", out_valid_o); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        in_count_i  = '0;
        out_ready_i = 1'b0;
`ifdef BURST_SPLIT_ERR_EN
        clr_err_i   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_bad_count();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
